// File: rtl/id_exe_pipe_reg.sv
// ============================================================================
//  Module   : id_exe_pipe_reg
//  Purpose  : ID/EXE pipeline register with hazard bubbles and stall counters
//  Revision : 1.0
// ============================================================================
`default_nettype none

module id_exe_pipe_reg #(
    parameter int CNT_W = 32,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_Valid,
    input  logic [31:0]      ID_PC,
    input  logic [31:0]      ID_Instr,
    input  logic [31:0]      ID_RsData,
    input  logic [31:0]      ID_RtData,
    input  logic [31:0]      ID_Imm32,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic [4:0]       ID_Dst,
    input  logic [4:0]       ID_ALUOp,
    input  logic             ID_RegWr,
    input  logic             ID_ReadMEM,
    input  logic             ID_WriteMEM,
    input  logic             ID_EX_DH_Stall,
    input  logic             ID_MEM1_DH_Stall,
    input  logic             ID_MEM2_DH_Stall,
    input  logic             EXE_Stall,
    input  logic             Flush,
    input  logic             BranchFlush,
    input  logic             CntClear,
    output logic             EXE_Valid,
    output logic [31:0]      EXE_PC,
    output logic [31:0]      EXE_Instr,
    output logic [31:0]      EXE_RsData,
    output logic [31:0]      EXE_RtData,
    output logic [31:0]      EXE_Imm32,
    output logic [4:0]       EXE_rs,
    output logic [4:0]       EXE_rt,
    output logic [4:0]       EXE_Dst,
    output logic [4:0]       EXE_ALUOp,
    output logic             EXE_RegWr,
    output logic             EXE_ReadMEM,
    output logic             EXE_WriteMEM,
    output logic             ID_Stall,
    output logic [CNT_W-1:0] StallCnt_EX,
    output logic [CNT_W-1:0] StallCnt_MEM1,
    output logic [CNT_W-1:0] StallCnt_MEM2,
    output logic [RUN_W-1:0] StallRun,
    output logic [RUN_W-1:0] MaxStallRun
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] c_RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] c_RUN_MAX = {RUN_W{1'b1}};

    logic             w_dh;
    logic             w_load_bubble;
    logic             w_count_en;
    logic             w_inc_ex;
    logic             w_inc_mem1;
    logic             w_inc_mem2;
    logic             w_inc_any;

    logic             valid_d,    valid_q;
    logic [31:0]      pc_d,       pc_q;
    logic [31:0]      instr_d,    instr_q;
    logic [31:0]      rs_data_d,  rs_data_q;
    logic [31:0]      rt_data_d,  rt_data_q;
    logic [31:0]      imm32_d,    imm32_q;
    logic [4:0]       rs_d,       rs_q;
    logic [4:0]       rt_d,       rt_q;
    logic [4:0]       dst_d,      dst_q;
    logic [4:0]       alu_op_d,   alu_op_q;
    logic             reg_wr_d,   reg_wr_q;
    logic             read_mem_d, read_mem_q;
    logic             write_mem_d, write_mem_q;

    logic [CNT_W-1:0] cnt_ex_d,   cnt_ex_q;
    logic [CNT_W-1:0] cnt_mem1_d, cnt_mem1_q;
    logic [CNT_W-1:0] cnt_mem2_d, cnt_mem2_q;
    logic [RUN_W-1:0] run_d,      run_q;
    logic [RUN_W-1:0] max_run_d,  max_run_q;

    // Hazard qualification and bundle control
    always_comb begin
        w_dh          = ID_Valid & (ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall);
        ID_Stall      = ~Flush & (EXE_Stall | (w_dh & ~BranchFlush));
        // Flush overrides back-pressure; BranchFlush and DH only act when EXE accepts.
        w_load_bubble = Flush | (~EXE_Stall & (BranchFlush | w_dh));
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm32_d     = imm32_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        dst_d       = dst_q;
        alu_op_d    = alu_op_q;
        reg_wr_d    = reg_wr_q;
        read_mem_d  = read_mem_q;
        write_mem_d = write_mem_q;
        if (w_load_bubble) begin
            valid_d     = 1'b0;
            pc_d        = 32'd0;
            instr_d     = 32'd0;
            rs_data_d   = 32'd0;
            rt_data_d   = 32'd0;
            imm32_d     = 32'd0;
            rs_d        = 5'd0;
            rt_d        = 5'd0;
            dst_d       = 5'd0;
            alu_op_d    = 5'd0;
            reg_wr_d    = 1'b0;
            read_mem_d  = 1'b0;
            write_mem_d = 1'b0;
        end else if (!EXE_Stall) begin
            valid_d     = ID_Valid;
            pc_d        = ID_PC;
            instr_d     = ID_Instr;
            rs_data_d   = ID_RsData;
            rt_data_d   = ID_RtData;
            imm32_d     = ID_Imm32;
            rs_d        = ID_rs;
            rt_d        = ID_rt;
            dst_d       = ID_Dst;
            alu_op_d    = ID_ALUOp;
            reg_wr_d    = ID_RegWr;
            read_mem_d  = ID_ReadMEM;
            write_mem_d = ID_WriteMEM;
        end
    end

    // Only one cause is charged per cycle, EX first, should several be raised.
    always_comb begin
        w_count_en = ~Flush & ~EXE_Stall & ID_Valid;
        w_inc_ex   = w_count_en & ID_EX_DH_Stall;
        w_inc_mem1 = w_count_en & ~ID_EX_DH_Stall & ID_MEM1_DH_Stall;
        w_inc_mem2 = w_count_en & ~ID_EX_DH_Stall & ~ID_MEM1_DH_Stall & ID_MEM2_DH_Stall;
        w_inc_any  = w_inc_ex | w_inc_mem1 | w_inc_mem2;
    end

    always_comb begin
        cnt_ex_d   = cnt_ex_q;
        cnt_mem1_d = cnt_mem1_q;
        cnt_mem2_d = cnt_mem2_q;
        run_d      = run_q;
        if (CntClear) begin
            cnt_ex_d   = '0;
            cnt_mem1_d = '0;
            cnt_mem2_d = '0;
            run_d      = '0;
        end else begin
            if (w_inc_ex && cnt_ex_q != c_CNT_MAX) begin
                cnt_ex_d = cnt_ex_q + c_CNT_ONE;
            end
            if (w_inc_mem1 && cnt_mem1_q != c_CNT_MAX) begin
                cnt_mem1_d = cnt_mem1_q + c_CNT_ONE;
            end
            if (w_inc_mem2 && cnt_mem2_q != c_CNT_MAX) begin
                cnt_mem2_d = cnt_mem2_q + c_CNT_ONE;
            end
            if (w_inc_any) begin
                if (run_q != c_RUN_MAX) begin
                    run_d = run_q + c_RUN_ONE;
                end
            end else if (!EXE_Stall) begin
                run_d = '0;
            end
        end
    end

    always_comb begin
        if (CntClear) begin
            max_run_d = '0;
        end else if (run_d > max_run_q) begin
            max_run_d = run_d;
        end else begin
            max_run_d = max_run_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= 32'd0;
            instr_q     <= 32'd0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm32_q     <= 32'd0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            dst_q       <= 5'd0;
            alu_op_q    <= 5'd0;
            reg_wr_q    <= 1'b0;
            read_mem_q  <= 1'b0;
            write_mem_q <= 1'b0;
            cnt_ex_q    <= '0;
            cnt_mem1_q  <= '0;
            cnt_mem2_q  <= '0;
            run_q       <= '0;
            max_run_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm32_q     <= imm32_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dst_q       <= dst_d;
            alu_op_q    <= alu_op_d;
            reg_wr_q    <= reg_wr_d;
            read_mem_q  <= read_mem_d;
            write_mem_q <= write_mem_d;
            cnt_ex_q    <= cnt_ex_d;
            cnt_mem1_q  <= cnt_mem1_d;
            cnt_mem2_q  <= cnt_mem2_d;
            run_q       <= run_d;
            max_run_q   <= max_run_d;
        end
    end

    assign EXE_Valid     = valid_q;
    assign EXE_PC        = pc_q;
    assign EXE_Instr     = instr_q;
    assign EXE_RsData    = rs_data_q;
    assign EXE_RtData    = rt_data_q;
    assign EXE_Imm32     = imm32_q;
    assign EXE_rs        = rs_q;
    assign EXE_rt        = rt_q;
    assign EXE_Dst       = dst_q;
    assign EXE_ALUOp     = alu_op_q;
    assign EXE_RegWr     = reg_wr_q;
    assign EXE_ReadMEM   = read_mem_q;
    assign EXE_WriteMEM  = write_mem_q;
    assign StallCnt_EX   = cnt_ex_q;
    assign StallCnt_MEM1 = cnt_mem1_q;
    assign StallCnt_MEM2 = cnt_mem2_q;
    assign StallRun      = run_q;
    assign MaxStallRun   = max_run_q;

endmodule

`default_nettype wire

// File: tb/tb_id_exe_pipe_reg.sv
// ============================================================================
//  Module   : tb_id_exe_pipe_reg
//  Purpose  : Directed vector bench for id_exe_pipe_reg (CNT_W=4, RUN_W=4)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_exe_pipe_reg;

    localparam int CNT_W = 4;
    localparam int RUN_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ID_Valid;
    logic [31:0] ID_PC, ID_Instr, ID_RsData, ID_RtData, ID_Imm32;
    logic [4:0]  ID_rs, ID_rt, ID_Dst, ID_ALUOp;
    logic        ID_RegWr, ID_ReadMEM, ID_WriteMEM;
    logic        ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall;
    logic        EXE_Stall, Flush, BranchFlush, CntClear;
    logic        EXE_Valid;
    logic [31:0] EXE_PC, EXE_Instr, EXE_RsData, EXE_RtData, EXE_Imm32;
    logic [4:0]  EXE_rs, EXE_rt, EXE_Dst, EXE_ALUOp;
    logic        EXE_RegWr, EXE_ReadMEM, EXE_WriteMEM;
    logic        ID_Stall;
    logic [CNT_W-1:0] StallCnt_EX, StallCnt_MEM1, StallCnt_MEM2;
    logic [RUN_W-1:0] StallRun, MaxStallRun;

    id_exe_pipe_reg #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_Instr(ID_Instr),
        .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm32(ID_Imm32),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_Dst(ID_Dst), .ID_ALUOp(ID_ALUOp),
        .ID_RegWr(ID_RegWr), .ID_ReadMEM(ID_ReadMEM), .ID_WriteMEM(ID_WriteMEM),
        .ID_EX_DH_Stall(ID_EX_DH_Stall), .ID_MEM1_DH_Stall(ID_MEM1_DH_Stall),
        .ID_MEM2_DH_Stall(ID_MEM2_DH_Stall), .EXE_Stall(EXE_Stall), .Flush(Flush),
        .BranchFlush(BranchFlush), .CntClear(CntClear),
        .EXE_Valid(EXE_Valid), .EXE_PC(EXE_PC), .EXE_Instr(EXE_Instr),
        .EXE_RsData(EXE_RsData), .EXE_RtData(EXE_RtData), .EXE_Imm32(EXE_Imm32),
        .EXE_rs(EXE_rs), .EXE_rt(EXE_rt), .EXE_Dst(EXE_Dst), .EXE_ALUOp(EXE_ALUOp),
        .EXE_RegWr(EXE_RegWr), .EXE_ReadMEM(EXE_ReadMEM), .EXE_WriteMEM(EXE_WriteMEM),
        .ID_Stall(ID_Stall), .StallCnt_EX(StallCnt_EX), .StallCnt_MEM1(StallCnt_MEM1),
        .StallCnt_MEM2(StallCnt_MEM2), .StallRun(StallRun), .MaxStallRun(MaxStallRun)
    );

    logic [183:0] act_bundle;
    assign act_bundle = {EXE_Valid, EXE_PC, EXE_Instr, EXE_RsData, EXE_RtData, EXE_Imm32,
                         EXE_rs, EXE_rt, EXE_Dst, EXE_ALUOp, EXE_RegWr, EXE_ReadMEM, EXE_WriteMEM};

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [2:0]  dh;      // {EX, MEM1, MEM2}
        logic        es, fl, bf, clr;
        logic        e_idst;
        logic        e_bub;
        logic        e_v;
        logic [31:0] e_pc;
        logic [3:0]  e_ex, e_m1, e_m2, e_run, e_max;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Every ID field is a fixed function of the PC, so an EXE bundle identifies its source.
    function automatic logic [183:0] mk_bundle(logic bub, logic v, logic [31:0] pc);
        logic [4:0] r;
        r = pc[6:2];
        if (bub) return '0;
        return {v, pc, {pc[15:0], 16'h1234}, pc + 32'h11, pc + 32'h22, ~pc,
                r, r + 5'd1, r + 5'd2, pc[4:0] ^ 5'h1f, 1'b1, pc[2], pc[3]};
    endfunction

    task automatic drive(logic v, logic [31:0] pc, logic [2:0] dh, logic es, logic fl,
                         logic bf, logic clr);
        ID_Valid = v; ID_PC = pc;
        ID_Instr = {pc[15:0], 16'h1234}; ID_RsData = pc + 32'h11; ID_RtData = pc + 32'h22;
        ID_Imm32 = ~pc; ID_rs = pc[6:2]; ID_rt = pc[6:2] + 5'd1; ID_Dst = pc[6:2] + 5'd2;
        ID_ALUOp = pc[4:0] ^ 5'h1f; ID_RegWr = 1'b1; ID_ReadMEM = pc[2]; ID_WriteMEM = pc[3];
        ID_EX_DH_Stall = dh[2]; ID_MEM1_DH_Stall = dh[1]; ID_MEM2_DH_Stall = dh[0];
        EXE_Stall = es; Flush = fl; BranchFlush = bf; CntClear = clr;
    endtask

    task automatic chk(string name, int row, logic [183:0] act, logic [183:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_stats(int row, logic [3:0] ex, logic [3:0] m1, logic [3:0] m2,
                             logic [3:0] run, logic [3:0] mx);
        chk("cnt_ex",   row, 184'(StallCnt_EX),   184'(ex));
        chk("cnt_mem1", row, 184'(StallCnt_MEM1), 184'(m1));
        chk("cnt_mem2", row, 184'(StallCnt_MEM2), 184'(m2));
        chk("run",      row, 184'(StallRun),      184'(run));
        chk("max_run",  row, 184'(MaxStallRun),   184'(mx));
    endtask

    function automatic void add(logic v, logic [31:0] pc, logic [2:0] dh, logic es, logic fl,
                                logic bf, logic clr, logic idst, logic bub, logic ev,
                                logic [31:0] epc, logic [3:0] ex, logic [3:0] m1,
                                logic [3:0] m2, logic [3:0] run, logic [3:0] mx);
        vec_t t;
        t.v = v; t.pc = pc; t.dh = dh; t.es = es; t.fl = fl; t.bf = bf; t.clr = clr;
        t.e_idst = idst; t.e_bub = bub; t.e_v = ev; t.e_pc = epc;
        t.e_ex = ex; t.e_m1 = m1; t.e_m2 = m2; t.e_run = run; t.e_max = mx;
        vecs.push_back(t);
    endfunction

    initial begin
        int r;
        logic [3:0] run;
        // v  pc        dh    es fl bf clr | idst bub ev epc        ex m1 m2 run max
        add(1, 32'h100, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h100,   0, 0, 0, 0, 0);
        add(1, 32'h104, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h104,   0, 0, 0, 0, 0);
        add(1, 32'h200, 3'b100, 0, 0, 0, 0,  1, 1, 0, 32'h0,     1, 0, 0, 1, 1);
        add(1, 32'h200, 3'b010, 0, 0, 0, 0,  1, 1, 0, 32'h0,     1, 1, 0, 2, 2);
        add(1, 32'h200, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h200,   1, 1, 0, 0, 2);
        for (int i = 0; i < 3; i++)
            add(1, 32'h204, 3'b001, 1, 0, 0, 0,  1, 0, 1, 32'h200,   1, 1, 0, 0, 2);
        add(1, 32'h204, 3'b001, 0, 0, 0, 0,  1, 1, 0, 32'h0,     1, 1, 1, 1, 2);
        add(1, 32'h204, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h204,   1, 1, 1, 0, 2);
        add(1, 32'h208, 3'b100, 1, 1, 0, 0,  0, 1, 0, 32'h0,     1, 1, 1, 0, 2);
        add(1, 32'h208, 3'b100, 0, 1, 0, 0,  0, 1, 0, 32'h0,     1, 1, 1, 0, 2);
        add(1, 32'h20C, 3'b000, 0, 0, 1, 0,  0, 1, 0, 32'h0,     1, 1, 1, 0, 2);
        add(1, 32'h210, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h210,   1, 1, 1, 0, 2);
        add(1, 32'h214, 3'b000, 1, 0, 1, 0,  1, 0, 1, 32'h210,   1, 1, 1, 0, 2);
        add(1, 32'h214, 3'b000, 0, 0, 1, 0,  0, 1, 0, 32'h0,     1, 1, 1, 0, 2);
        for (int i = 0; i < 20; i++) begin
            run = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            add(1, 32'h218, 3'b100, 0, 0, 0, 0,  1, 1, 0, 32'h0,
                (i + 2 > 15) ? 4'd15 : 4'(i + 2), 1, 1, run, (run > 4'd2) ? run : 4'd2);
        end
        add(1, 32'h218, 3'b100, 0, 0, 0, 1,  1, 1, 0, 32'h0,     0, 0, 0, 0, 0);
        add(1, 32'h21C, 3'b111, 0, 0, 0, 0,  1, 1, 0, 32'h0,     1, 0, 0, 1, 1);
        add(1, 32'h21C, 3'b011, 0, 0, 0, 0,  1, 1, 0, 32'h0,     1, 1, 0, 2, 2);
        add(1, 32'h21C, 3'b000, 0, 0, 0, 0,  0, 0, 1, 32'h21C,   1, 1, 0, 0, 2);
        add(0, 32'h224, 3'b100, 0, 0, 0, 0,  0, 0, 0, 32'h224,   1, 1, 0, 0, 2);
        for (int i = 0; i < 5; i++)
            add(1, 32'h228, 3'b001, 0, 0, 0, 0,  1, 1, 0, 32'h0,
                1, 1, 4'(i + 1), 4'(i + 1), (i + 1 > 2) ? 4'(i + 1) : 4'd2);

        rst = 1'b1;
        drive(0, 32'h0, 3'b000, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bundle", -1, act_bundle, '0);
        chk("reset_id_stall", -1, 184'(ID_Stall), 184'(0));
        chk_stats(-1, 0, 0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        for (r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            drive(vecs[r].v, vecs[r].pc, vecs[r].dh, vecs[r].es, vecs[r].fl, vecs[r].bf,
                  vecs[r].clr);
            #1;
            chk("id_stall", r, 184'(ID_Stall), 184'(vecs[r].e_idst));
            @(posedge clk);
            #1;
            chk("bundle", r, act_bundle, mk_bundle(vecs[r].e_bub, vecs[r].e_v, vecs[r].e_pc));
            chk_stats(r, vecs[r].e_ex, vecs[r].e_m1, vecs[r].e_m2, vecs[r].e_run, vecs[r].e_max);
        end

        // Reset mid-stall (StallRun=5): DH still raised, ID_Stall still follows its equation.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'h228, 3'b001, 0, 0, 0, 0);
        #1;
        chk("rst_id_stall", 100, 184'(ID_Stall), 184'(1));
        @(posedge clk);
        #1;
        chk("rst_bundle", 100, act_bundle, '0);
        chk_stats(100, 0, 0, 0, 0, 0);

        // Capture a real bundle, then reset clears it.
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h300, 3'b000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("cap_300", 101, act_bundle, mk_bundle(0, 1, 32'h300));
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'h304, 3'b000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_clears_300", 102, act_bundle, '0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
